// File: rtl/secure_parity_router.sv
// Password-gated router: authenticates a requester, then steers each confirmed
// data word to the odd or even output register by its LSB.
module secure_parity_router #(
  parameter int DATA_W      = 4,
  parameter int PASS_W      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int TIMEOUT     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PASS_W-1:0] machine_pass,
  input  logic              request,
  input  logic              confirm,
  input  logic [PASS_W-1:0] password,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] ODOUT,
  output logic [DATA_W-1:0] EDOUT,
  output logic              odd_valid,
  output logic              even_valid,
  output logic              granted,
  output logic              locked
);

  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_TRIES - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    LOCKED
  } state_t;

  state_t            state, state_nx;
  logic [FAIL_W-1:0] fail_cnt, fail_nx;
  logic [LOCK_W-1:0] lock_cnt, lock_nx;
  logic [TO_W-1:0]   to_cnt, to_nx;
  logic              confirm_q;
  logic              cev;
  logic              load_odd, load_even;

  // A held confirm produces exactly one event on its rising edge.
  assign cev = confirm & ~confirm_q;

  always_comb begin
    state_nx  = state;
    fail_nx   = fail_cnt;
    lock_nx   = lock_cnt;
    to_nx     = to_cnt;
    load_odd  = 1'b0;
    load_even = 1'b0;
    case (state)
      IDLE: begin
        lock_nx = '0;
        to_nx   = '0;
        if (request && cev) begin
          if (password == machine_pass) begin
            state_nx = GRANTED;
            fail_nx  = '0;
          end else if (fail_cnt == FAIL_LAST) begin
            state_nx = LOCKED;
            fail_nx  = '0;
          end else begin
            fail_nx = fail_cnt + 1'b1;
          end
        end
      end
      GRANTED: begin
        // Dropping request wins over a coincident confirm event.
        if (!request) begin
          state_nx = IDLE;
          to_nx    = '0;
        end else if (cev) begin
          to_nx     = '0;
          load_odd  = data[0];
          load_even = ~data[0];
        end else if (to_cnt == TO_LAST) begin
          state_nx = IDLE;
          to_nx    = '0;
        end else begin
          to_nx = to_cnt + 1'b1;
        end
      end
      LOCKED: begin
        if (lock_cnt == LOCK_LAST) begin
          state_nx = IDLE;
          lock_nx  = '0;
        end else begin
          lock_nx = lock_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fail_cnt   <= '0;
      lock_cnt   <= '0;
      to_cnt     <= '0;
      confirm_q  <= 1'b0;
      ODOUT      <= '0;
      EDOUT      <= '0;
      odd_valid  <= 1'b0;
      even_valid <= 1'b0;
    end else begin
      state      <= state_nx;
      fail_cnt   <= fail_nx;
      lock_cnt   <= lock_nx;
      to_cnt     <= to_nx;
      confirm_q  <= confirm;
      odd_valid  <= load_odd;
      even_valid <= load_even;
      if (load_odd)  ODOUT <= data;
      if (load_even) EDOUT <= data;
    end
  end

  assign granted = (state == GRANTED);
  assign locked  = (state == LOCKED);

endmodule

// File: tb/tb_secure_parity_router.sv
// Randomized scoreboard bench for secure_parity_router with a cycle-level
// behavioural model of sessions, lockout and timeout.
module tb_secure_parity_router;
  localparam int DATA_W      = 4;
  localparam int PASS_W      = 4;
  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 16;
  localparam int TIMEOUT     = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [PASS_W-1:0] machine_pass = '0;
  logic              request = 1'b0;
  logic              confirm = 1'b0;
  logic [PASS_W-1:0] password = '0;
  logic [DATA_W-1:0] data = '0;
  logic [DATA_W-1:0] ODOUT, EDOUT;
  logic              odd_valid, even_valid, granted, locked;

  secure_parity_router #(
    .DATA_W(DATA_W), .PASS_W(PASS_W), .MAX_TRIES(MAX_TRIES),
    .LOCK_CYCLES(LOCK_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .machine_pass(machine_pass), .request(request),
    .confirm(confirm), .password(password), .data(data), .ODOUT(ODOUT),
    .EDOUT(EDOUT), .odd_valid(odd_valid), .even_valid(even_valid),
    .granted(granted), .locked(locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef enum int {M_IDLE, M_GRANT, M_LOCK} mstate_t;
  typedef struct packed {
    logic              odd;
    logic [DATA_W-1:0] val;
  } xfer_t;

  mstate_t           m_state;
  int                m_wrong, m_quiet, m_lock;
  bit                m_prevc, m_cev, m_op, m_ep;
  logic [DATA_W-1:0] m_od, m_ed;
  xfer_t             sb[$];
  xfer_t             mx;

  // Reference model: tracks session state from the rules, not the RTL encoding.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = M_IDLE;
      m_wrong = 0; m_quiet = 0; m_lock = 0;
      m_prevc = 1'b0; m_op = 1'b0; m_ep = 1'b0;
      m_od = '0; m_ed = '0;
      sb.delete();
    end else begin
      m_cev = confirm && !m_prevc;
      m_prevc = confirm;
      m_op = 1'b0;
      m_ep = 1'b0;
      case (m_state)
        M_IDLE: begin
          if (request && m_cev) begin
            if (password == machine_pass) begin
              m_state = M_GRANT; m_quiet = 0; m_wrong = 0;
            end else begin
              m_wrong++;
              if (m_wrong >= MAX_TRIES) begin
                m_state = M_LOCK; m_lock = 0; m_wrong = 0;
              end
            end
          end
        end
        M_GRANT: begin
          if (!request) m_state = M_IDLE;
          else if (m_cev) begin
            m_quiet = 0;
            if (data[0]) begin m_od = data; m_op = 1'b1; end
            else begin m_ed = data; m_ep = 1'b1; end
            sb.push_back(xfer_t'{odd: data[0], val: data});
          end else begin
            m_quiet++;
            if (m_quiet >= TIMEOUT) m_state = M_IDLE;
          end
        end
        default: begin
          m_lock++;
          if (m_lock >= LOCK_CYCLES) m_state = M_IDLE;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("granted", 32'(granted), 32'(m_state == M_GRANT));
    chk("locked", 32'(locked), 32'(m_state == M_LOCK));
    chk("odd_valid", 32'(odd_valid), 32'(m_op));
    chk("even_valid", 32'(even_valid), 32'(m_ep));
    chk("ODOUT", 32'(ODOUT), 32'(m_od));
    chk("EDOUT", 32'(EDOUT), 32'(m_ed));
    if (odd_valid || even_valid) begin
      chk("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        mx = sb.pop_front();
        chk("pulse_kind", 32'(odd_valid), 32'(mx.odd));
        chk("pulse_word", 32'(odd_valid ? ODOUT : EDOUT), 32'(mx.val));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_confirm();
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    tick();
  endtask

  int conf_div;

  initial begin
    machine_pass = 4'hA;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    // auth and route
    request = 1'b1; password = 4'hA;
    pulse_confirm();
    data = 4'h3; pulse_confirm();
    data = 4'h0; pulse_confirm();
    tick(2);
    // held confirm yields a single transfer
    data = 4'h5; confirm = 1'b1; tick(5); confirm = 1'b0; tick(2);
    // reset in the middle of a session
    #2 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    pulse_confirm();
    data = 4'h6; pulse_confirm();
    request = 1'b0; tick(2);
    // lockout, correct password ignored while locked
    request = 1'b1; password = 4'h8;
    repeat (3) pulse_confirm();
    password = 4'hA;
    repeat (4) pulse_confirm();
    tick(12);
    request = 1'b0; tick(2);
    // timeout
    request = 1'b1;
    pulse_confirm();
    tick(40);
    // request falling together with confirm event
    pulse_confirm();
    data = 4'h1; request = 1'b0; confirm = 1'b1;
    tick();
    confirm = 1'b0;
    tick(3);
    // randomized traffic in phases of varying confirm density
    for (int ph = 0; ph < 10; ph++) begin
      conf_div = (ph % 3 == 0) ? 2 : ((ph % 3 == 1) ? 5 : 60);
      for (int c = 0; c < 300; c++) begin
        request  = ($urandom_range(0, 19) != 0);
        confirm  = ($urandom_range(0, conf_div - 1) == 0);
        password = ($urandom_range(0, 1) == 0) ? machine_pass : PASS_W'($urandom);
        data     = DATA_W'($urandom);
        if ($urandom_range(0, 399) == 0) begin
          #2 rst_n = 1'b0;
          tick();
          rst_n = 1'b1;
        end else begin
          tick();
        end
      end
    end
    request = 1'b0; confirm = 1'b0;
    tick(3);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
